// File: rtl/stage_pkg.sv
// -----------------------------------------------------------------------------
// stage_pkg
// Shared definitions for the stage_skid_fifo slice:
//   stage_state_e : occupancy state of the FIFO controller
//   ptr_w()       : pointer width for a given storage depth
// -----------------------------------------------------------------------------
package stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    // A depth of 1 would give a zero-width pointer; clamp to one bit.
    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/stage_fifo_mem.sv
// -----------------------------------------------------------------------------
// stage_fifo_mem
// DEPTH x WIDTH_S register array with one write port and a registered read.
// Ports:
//   clk, rst_n        : clock, async active-low reset (read register only)
//   wr_en             : write strobe
//   wr_addr, wr_data  : write address / payload
//   rd_addr           : address to load into the read register this edge
//   rd_data           : registered read data
// A write to the address being read this edge is forwarded into the read
// register, so a word written into an empty FIFO is visible one edge later.
// -----------------------------------------------------------------------------
module stage_fifo_mem
    import stage_pkg::*;
#(
    parameter int WIDTH_S = 8,
    parameter int DEPTH   = 4,
    parameter int AW      = ptr_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WIDTH_S-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [WIDTH_S-1:0] rd_data
);

    logic [WIDTH_S-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (wr_en && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/stage_skid_fifo.sv
// -----------------------------------------------------------------------------
// stage_skid_fifo
// Registered-output FIFO stage with valid/ready on both sides and a sticky
// upstream protocol checker.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_data      : upstream word
//   in_ready              : block accepts a word this cycle (from state reg)
//   out_valid/out_data    : oldest stored word (from registers)
//   out_ready             : downstream accepts a word this cycle
//   level                 : stored word count, 0..DEPTH
//   proto_err / clr_err   : sticky upstream violation flag / its clear
//   fsm_state             : current controller state (stage_state_e encoding)
// Handshake: a word moves on a rising edge when valid and ready are both high
// on that side; once valid is raised upstream it must hold valid and data
// stable until accepted, otherwise proto_err is set.
// -----------------------------------------------------------------------------
module stage_skid_fifo
    import stage_pkg::*;
#(
    parameter int WIDTH_S = 8,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [WIDTH_S-1:0]         in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH_S-1:0]         out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       proto_err,
    input  logic                       clr_err,
    output logic [1:0]                 fsm_state
);

    localparam int AW = ptr_w(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);

    stage_state_e      state_q, state_d;
    logic [AW-1:0]     wr_ptr, rd_ptr, rd_addr;
    logic [LW-1:0]     level_q;
    logic              wr_fire, rd_fire;
    logic              stall_q;
    logic [WIDTH_S-1:0] stall_data_q;
    logic              err_set;

    assign wr_fire = in_valid & in_ready;
    assign rd_fire = out_valid & out_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (wr_fire) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (wr_fire && !rd_fire && (level_q == LVL_FULL - LVL_ONE)) begin
                    state_d = ST_FULL;
                end else if (rd_fire && !wr_fire && (level_q == LVL_ONE)) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (rd_fire) state_d = ST_BUSY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // ---------------- FSM: outputs (decoded from the state register) -------
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state_q)
            ST_EMPTY: begin in_ready = 1'b1; out_valid = 1'b0; end
            ST_BUSY:  begin in_ready = 1'b1; out_valid = 1'b1; end
            ST_FULL:  begin in_ready = 1'b0; out_valid = 1'b1; end
            default:  begin in_ready = 1'b1; out_valid = 1'b0; end
        endcase
    end

    assign fsm_state = state_q;
    assign level     = level_q;

    // ---------------- pointers and level ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
            if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_fire, rd_fire})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // The read register is loaded with the word that will be oldest after
    // this edge, so out_data always shows the head without a comb path.
    assign rd_addr = rd_fire ? (rd_ptr + AW'(1)) : rd_ptr;

    stage_fifo_mem #(
        .WIDTH_S (WIDTH_S),
        .DEPTH   (DEPTH),
        .AW      (AW)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (out_data)
    );

    // ---------------- upstream protocol checker ----------------
    // A stalled offer (valid without ready) must be repeated unchanged.
    assign err_set = stall_q && (!in_valid || (in_data != stall_data_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q      <= 1'b0;
            stall_data_q <= '0;
            proto_err    <= 1'b0;
        end else begin
            stall_q      <= in_valid & ~in_ready;
            stall_data_q <= in_data;
            if (err_set) begin
                proto_err <= 1'b1;
            end else if (clr_err) begin
                proto_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stage_skid_fifo.sv
// -----------------------------------------------------------------------------
// tb_stage_skid_fifo
// Directed scenarios followed by random traffic. The driver applies inputs
// just after each rising edge and advances a word-queue reference model; a
// monitor on the falling edge compares the DUT against that model.
// -----------------------------------------------------------------------------
module tb_stage_skid_fifo;
    import stage_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready = 1'b0;
    logic [LW-1:0] level;
    logic          proto_err;
    logic          clr_err = 1'b0;
    logic [1:0]    fsm_state;

    stage_skid_fifo #(.WIDTH_S(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level),
        .proto_err (proto_err),
        .clr_err   (clr_err),
        .fsm_state (fsm_state)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           m_level;
    logic         m_err;
    logic         m_prev_stall;
    logic [W-1:0] m_prev_data;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_level      = 0;
        m_err        = 1'b0;
        m_prev_stall = 1'b0;
        m_prev_data  = '0;
    endtask

    // Called just after a rising edge: drive inputs, wait one edge, then
    // account for what that edge did according to the FIFO rules.
    task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy, input logic clr);
        logic rdy, ov, wr, rd, set;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clr_err   = clr;
        rdy = (m_level < DEPTH);
        ov  = (m_level > 0);
        @(posedge clk);
        #1;
        wr  = v && rdy;
        rd  = ov && ordy;
        set = m_prev_stall && (!v || (d != m_prev_data));
        if (set)      m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        m_prev_stall = v && !rdy;
        m_prev_data  = d;
        if (wr) exp_q.push_back(d);
        m_level = m_level + int'(wr) - int'(rd);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            logic [1:0] exp_st;
            exp_st = (m_level == 0) ? 2'(ST_EMPTY) :
                     (m_level == DEPTH) ? 2'(ST_FULL) : 2'(ST_BUSY);
            check("level", 32'(level), 32'(m_level));
            check("in_ready", 32'(in_ready), 32'(m_level < DEPTH));
            check("out_valid", 32'(out_valid), 32'(m_level > 0));
            check("proto_err", 32'(proto_err), 32'(m_err));
            check("fsm_state", 32'(fsm_state), 32'(exp_st));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("head_present", 32'(1), 32'(0));
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_level", 32'(level), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_proto_err", 32'(proto_err), 32'(0));

        // Fill with the consumer stalled.
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        check("first_latency", 32'(out_data), 32'h11);
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        drive(1'b1, 8'h44, 1'b0, 1'b0);
        check("fill_level", 32'(level), 32'(4));
        check("fill_in_ready", 32'(in_ready), 32'(0));
        check("fill_head", 32'(out_data), 32'h11);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("fill_hold", 32'(out_data), 32'h11);

        // Drain.
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("drain_out_valid", 32'(out_valid), 32'(0));
        check("drain_level", 32'(level), 32'(0));

        // Streaming with the consumer always ready.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, W'(i), 1'b1, 1'b0);
            check("stream_level", 32'(level), 32'(1));
            check("stream_data", 32'(out_data), 32'(i));
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Alternating write/read pairs: pointers wrap more than twice.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, W'(8'hC0 + i), 1'b0, 1'b0);
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("wrap_level", 32'(level), 32'(0));

        // Protocol violations while full.
        for (int i = 0; i < 4; i++) drive(1'b1, W'(8'h61 + i), 1'b0, 1'b0);
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        check("proto_quiet", 32'(proto_err), 32'(0));
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        check("proto_set", 32'(proto_err), 32'(1));
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        check("proto_sticky", 32'(proto_err), 32'(1));
        drive(1'b1, 8'hA5, 1'b0, 1'b1);
        check("proto_set_wins", 32'(proto_err), 32'(1));
        drive(1'b1, 8'hA5, 1'b1, 1'b1);
        check("proto_clear", 32'(proto_err), 32'(0));
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset with three words stored.
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        drive(1'b1, 8'h02, 1'b0, 1'b0);
        drive(1'b1, 8'h03, 1'b0, 1'b0);
        check("pre_reset_level", 32'(level), 32'(3));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_out_valid", 32'(out_valid), 32'(0));
        check("async_level", 32'(level), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        check("post_reset_valid", 32'(out_valid), 32'(1));
        check("post_reset_data", 32'(out_data), 32'h77);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 7), W'($urandom_range(0, 255)),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0));
        end
        for (int i = 0; i < 8; i++) begin
            if (m_level > 0) drive(1'b0, 8'h00, 1'b1, 1'b1);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        check("final_empty", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
